// File: rtl/output_fifo_8to16.sv
// Byte-to-word packing FIFO: pairs core bytes into 16-bit words, buffers them in a
// block RAM ring and presents them first-word-fall-through to the host read path.
module output_fifo_8to16 #(
  parameter int unsigned DEPTH_LOG2      = 10,
  parameter int unsigned PROG_FULL_WORDS = 768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  input  logic                  flush,
  output logic                  byte_pending,
  output logic [15:0]           dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   word_count
);

  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_PF  = CW'(PROG_FULL_WORDS);

  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [7:0]            r_held;
  logic                  r_pend;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_af;
  logic                  r_pf;
  logic [15:0]           r_q;
  logic                  r_q_valid;
  logic [15:0]           r_dout;
  logic                  r_out_valid;

  logic                  w_space;
  logic                  w_wr_acc;
  logic                  w_push;
  logic [15:0]           w_push_data;
  logic                  w_pend_nxt;
  logic [7:0]            w_held_nxt;
  logic                  w_pop;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CW-1:0]         w_ram_cnt;
  logic                  w_q_take;
  logic                  w_ram_rd;

  assign w_space  = (r_count != CNT_MAX);
  assign w_wr_acc = wr_en & ~r_full;

  // Packer: an incoming byte is handled before flush; at most one word per cycle.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_pend_nxt  = r_pend;
    w_held_nxt  = r_held;
    if (w_wr_acc) begin
      if (r_pend) begin
        w_push      = 1'b1;
        w_push_data = {din, r_held};
        w_pend_nxt  = 1'b0;
      end else if (flush && w_space) begin
        w_push      = 1'b1;
        w_push_data = {8'h00, din};
      end else begin
        w_held_nxt  = din;
        w_pend_nxt  = 1'b1;
      end
    end else if (r_pend && flush && w_space) begin
      w_push      = 1'b1;
      w_push_data = {8'h00, r_held};
      w_pend_nxt  = 1'b0;
    end
  end

  // Read pipeline: RAM read register feeds the output register; words still in RAM
  // are the total count minus whatever sits in the two pipeline stages.
  assign w_pop     = rd_en & r_out_valid;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_ram_cnt = r_count - CW'(r_q_valid) - CW'(r_out_valid);
  assign w_q_take  = r_q_valid & (~r_out_valid | w_pop);
  assign w_ram_rd  = (w_ram_cnt != '0) & (~r_q_valid | w_q_take);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    if (w_ram_rd) r_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_held      <= '0;
      r_pend      <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_af        <= 1'b0;
      r_pf        <= 1'b0;
      r_q_valid   <= 1'b0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_held  <= w_held_nxt;
      r_pend  <= w_pend_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= w_pend_nxt & (w_cnt_nxt == CNT_MAX);
      r_af    <= (w_cnt_nxt >= CNT_AF);
      r_pf    <= (w_cnt_nxt >= CNT_PF);
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_ram_rd) begin
        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
        r_q_valid <= 1'b1;
      end else if (w_q_take) begin
        r_q_valid <= 1'b0;
      end
      if (~r_out_valid | w_pop) begin
        r_out_valid <= r_q_valid;
        if (r_q_valid) r_dout <= r_q;
      end
    end
  end

  assign full         = r_full;
  assign almost_full  = r_af;
  assign prog_full    = r_pf;
  assign byte_pending = r_pend;
  assign dout         = r_dout;
  assign empty        = ~r_out_valid;
  assign word_count   = r_count;

endmodule

// File: tb/tb_output_fifo_8to16.sv
// Self-checking bench for output_fifo_8to16: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_output_fifo_8to16;

  localparam int DEPTH = 1024;
  localparam int PF    = 768;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic        full, almost_full, prog_full, byte_pending, empty;
  logic [15:0] dout;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;

  output_fifo_8to16 #(.DEPTH_LOG2(10), .PROG_FULL_WORDS(768)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .prog_full(prog_full), .flush(flush),
    .byte_pending(byte_pending), .dout(dout), .rd_en(rd_en), .empty(empty),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference model: stored words with the clock edge at which each was pushed.
  logic [15:0] mq[$];
  int          mt[$];
  bit          m_pend = 1'b0;
  logic [7:0]  m_held = 8'h00;
  int          cyc = 0;

  function automatic bit m_empty();
    return (mq.size() == 0) || (cyc < mt[0] + 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rs, input bit wr, input logic [7:0] d,
                            input bit fl, input bit rd);
    int sz;
    bit mfull, acc, space, pop, push;
    logic [15:0] w;
    if (rs) begin
      mq.delete(); mt.delete(); m_pend = 1'b0; m_held = 8'h00;
      cyc++;
      return;
    end
    sz    = mq.size();
    mfull = m_pend && (sz == DEPTH);
    acc   = wr && !mfull;
    space = (sz != DEPTH);
    pop   = rd && !m_empty();
    push  = 1'b0;
    w     = 16'h0000;
    if (acc && m_pend) begin
      push = 1'b1; w = {d, m_held}; m_pend = 1'b0;
    end else if (acc && fl && space) begin
      push = 1'b1; w = {8'h00, d};
    end else if (acc) begin
      m_held = d; m_pend = 1'b1;
    end else if (m_pend && fl && space) begin
      push = 1'b1; w = {8'h00, m_held}; m_pend = 1'b0;
    end
    if (pop) begin
      void'(mq.pop_front()); void'(mt.pop_front());
    end
    cyc++;
    if (push) begin
      mq.push_back(w); mt.push_back(cyc);
    end
  endtask

  task automatic compare_model();
    chk("empty", 32'(empty), 32'(m_empty()));
    chk("word_count", 32'(word_count), 32'(mq.size()));
    chk("byte_pending", 32'(byte_pending), 32'(m_pend));
    chk("full", 32'(full), 32'(m_pend && mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 1));
    chk("prog_full", 32'(prog_full), 32'(mq.size() >= PF));
    if (!m_empty()) chk("dout", 32'(dout), 32'(mq[0]));
  endtask

  task automatic step(input bit rs, input bit wr, input logic [7:0] d,
                      input bit fl, input bit rd);
    rst = rs; wr_en = wr; din = d; flush = fl; rd_en = rd;
    @(posedge clk);
    model_edge(rs, wr, d, fl, rd);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit          rs, wr, fl, rd;
    logic [7:0]  d;
    bit          e_empty, e_pend;
    int          e_cnt;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vt[15];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] last;
    int full_seen, pops, k, bound;

    vt[0]  = '{1,0,0,0,8'h00, 1,0,0,16'h0000};
    vt[1]  = '{0,1,0,0,8'h11, 1,1,0,16'h0000};
    vt[2]  = '{0,1,0,0,8'h22, 1,0,1,16'h0000};
    vt[3]  = '{0,0,0,0,8'h00, 1,0,1,16'h0000};
    vt[4]  = '{0,0,0,0,8'h00, 0,0,1,16'h2211};
    vt[5]  = '{0,0,0,1,8'h00, 1,0,0,16'h0000};
    vt[6]  = '{0,1,0,0,8'hA5, 1,1,0,16'h0000};
    vt[7]  = '{0,0,1,0,8'h00, 1,0,1,16'h0000};
    vt[8]  = '{0,0,1,0,8'h00, 1,0,1,16'h0000};
    vt[9]  = '{0,0,0,0,8'h00, 0,0,1,16'h00A5};
    vt[10] = '{0,0,0,1,8'h00, 1,0,0,16'h0000};
    vt[11] = '{0,1,1,0,8'h7E, 1,0,1,16'h0000};
    vt[12] = '{0,0,0,0,8'h00, 1,0,1,16'h0000};
    vt[13] = '{0,0,0,0,8'h00, 0,0,1,16'h007E};
    vt[14] = '{0,0,0,1,8'h00, 1,0,0,16'h0000};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      step(vt[i].rs, vt[i].wr, vt[i].d, vt[i].fl, vt[i].rd);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d_pending", i), 32'(byte_pending), 32'(vt[i].e_pend));
      chk($sformatf("vec%0d_count", i), 32'(word_count), 32'(vt[i].e_cnt));
      if (!vt[i].e_empty || vt[i].rs)
        chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].e_dout));
    end

    // Mid-operation reset with five words stored and a byte pending
    for (int i = 0; i < 11; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("pre_rst_count", 32'(word_count), 32'd5);
    step(1, 1, 8'hFF, 1, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_pending", 32'(byte_pending), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'h0000);
    step(0, 1, 8'h01, 0, 0);
    step(0, 1, 8'h02, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("post_rst_dout", 32'(dout), 32'h0201);
    step(0, 0, 8'h00, 0, 1);
    chk("post_rst_drain", 32'(word_count), 32'd0);

    // Fill to capacity, then exercise full gating
    for (int i = 0; i < 2048; i++) begin
      step(0, 1, 8'(i), 0, 0);
      if (i == 1533) chk("pf_below", 32'(prog_full), 32'd0);
      if (i == 1535) chk("pf_at_768", 32'(prog_full), 32'd1);
      if (i == 2043) chk("af_below", 32'(almost_full), 32'd0);
      if (i == 2045) chk("af_at_1023", 32'(almost_full), 32'd1);
    end
    chk("fill_count", 32'(word_count), 32'd1024);
    chk("fill_full", 32'(full), 32'd0);
    step(0, 1, 8'hC3, 0, 0);
    chk("latch_at_full_pending", 32'(byte_pending), 32'd1);
    chk("latch_at_full_full", 32'(full), 32'd1);
    step(0, 1, 8'hEE, 0, 0);
    chk("ignored_count", 32'(word_count), 32'd1024);
    chk("ignored_full", 32'(full), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    chk("pop_unfull_full", 32'(full), 32'd0);
    chk("pop_unfull_count", 32'(word_count), 32'd1023);
    step(0, 1, 8'h5A, 0, 0);
    chk("refill_count", 32'(word_count), 32'd1024);
    chk("refill_pending", 32'(byte_pending), 32'd0);
    last = 16'h0000;
    bound = 0;
    while (mq.size() != 0 && bound < 3000) begin
      if (!m_empty() && mq.size() == 1) last = dout;
      step(0, 0, 8'h00, 0, !m_empty());
      bound++;
    end
    chk("drain_done", 32'(mq.size()), 32'd0);
    chk("last_word", 32'(last), 32'h5AC3);

    // Streaming across pointer wrap with the reader keeping up
    full_seen = 0; pops = 0; k = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!m_empty()) begin
        chk("stream_order", 32'(dout), 32'({8'(2*k+1), 8'(2*k)}));
        k++; pops++;
      end
      step(0, 1, 8'(i), 0, !m_empty());
      if (full) full_seen++;
    end
    bound = 0;
    while (mq.size() != 0 && bound < 100) begin
      if (!m_empty()) begin
        chk("stream_order", 32'(dout), 32'({8'(2*k+1), 8'(2*k)}));
        k++; pops++;
      end
      step(0, 0, 8'h00, 0, !m_empty());
      bound++;
    end
    chk("stream_pops", 32'(pops), 32'd2000);
    chk("stream_never_full", 32'(full_seen), 32'd0);

    // Randomized traffic in phases of varying read pressure
    for (int ph = 0; ph < 8; ph++) begin
      int prd;
      prd = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(999) < 2, $urandom_range(99) < 85, 8'($urandom),
             $urandom_range(99) < 10, $urandom_range(99) < prd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
